// File: rtl/sseg_pkg.sv
// Shared types and constants for the four-digit seven-segment formatter.
package sseg_pkg;

    localparam int NDIG        = 4;
    localparam int MAX_POS     = 9999;
    localparam int MAX_NEG_MAG = 999;
    localparam int ITER        = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLAMP = 2'd1,
        SHIFT = 2'd2,
        PLACE = 2'd3
    } state_t;

    // Index of the most-significant non-zero BCD digit; 0 when all digits are zero.
    function automatic logic [1:0] msd_idx(input logic [NDIG*4-1:0] bcd);
        logic [1:0] m;
        m = 2'd0;
        for (int i = 1; i < NDIG; i++)
            if (bcd[i*4 +: 4] != 4'd0) m = 2'(i);
        return m;
    endfunction

endpackage

// File: rtl/sseg_digits_bcd_adj3.sv
// Double-dabble correction for one BCD nibble: add 3 when the nibble is 5 or more.
module bcd_adj3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/sseg_digits.sv
// Signed 16-bit to four-digit BCD display formatter with sign, decimal point and blanking.
// Define SSEG_DIGITS_LZB_EN to blank leading zeros and float the sign next to the leading digit.
module sseg_digits
    import sseg_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        dp_en,
    input  logic [1:0]  dp_sel,
    output logic        busy,
    output logic        done,
    output logic [15:0] num,
    output logic [3:0]  blank,
    output logic [3:0]  sign,
    output logic [3:0]  dp
);

    state_t state, state_nxt;

    logic [15:0] val_q;
    logic        dpen_q;
    logic [1:0]  dpsel_q;
    logic        neg_q;
    logic [3:0]  cnt;
    logic        commit;
    logic [29:0] sh;                 // {bcd[15:0], bin[13:0]}
    logic [NDIG-1:0][3:0] adj;
    logic [29:0] pre;

    logic [16:0] mag_full;
    logic [13:0] mag_c;

    logic [15:0] num_c,   num_p;
    logic [3:0]  blank_c, blank_p;
    logic [3:0]  sign_c,  sign_p;
    logic [3:0]  dp_c,    dp_p;
    logic [1:0]  spos;

    assign busy = (state != IDLE) || commit;

    for (genvar i = 0; i < NDIG; i++) begin : g_adj
        bcd_adj3 u_adj (.din(sh[14 + 4*i +: 4]), .dout(adj[i]));
    end
    assign pre = {adj, sh[13:0]};

    // Magnitude with the 17th bit so -32768 negates cleanly before clamping.
    always_comb begin
        mag_full = val_q[15] ? (17'd0 - {val_q[15], val_q}) : {1'b0, val_q};
        mag_c    = mag_full[13:0];
        if (!val_q[15] && mag_full > 17'(MAX_POS))
            mag_c = 14'(MAX_POS);
        else if (val_q[15] && mag_full > 17'(MAX_NEG_MAG))
            mag_c = 14'(MAX_NEG_MAG);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load && !commit) state_nxt = CLAMP;
            CLAMP:   state_nxt = SHIFT;
            SHIFT:   if (cnt == 4'(ITER - 1)) state_nxt = PLACE;
            PLACE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        num_c = sh[29:14];
`ifdef SSEG_DIGITS_LZB_EN
        spos = msd_idx(sh[29:14]) + 2'd1;
        for (int i = 0; i < NDIG; i++)
            blank_c[i] = 2'(i) > msd_idx(sh[29:14]);
`else
        spos    = 2'd3;
        blank_c = 4'b0000;
`endif
        sign_c = 4'b0000;
        for (int i = 0; i < NDIG; i++) begin
            if (neg_q && spos == 2'(i)) begin
                sign_c[i]      = 1'b1;
                blank_c[i]     = 1'b0;
                num_c[i*4 +: 4] = 4'd0;
            end
        end
        dp_c = dpen_q ? (4'b0001 << dpsel_q) : 4'b0000;
        dp_c = dp_c & ~(blank_c | sign_c);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            val_q   <= '0;
            dpen_q  <= 1'b0;
            dpsel_q <= '0;
            neg_q   <= 1'b0;
            cnt     <= '0;
            sh      <= '0;
            commit  <= 1'b0;
            num_p   <= '0;
            blank_p <= '0;
            sign_p  <= '0;
            dp_p    <= '0;
            done    <= 1'b0;
            num     <= '0;
            blank   <= 4'b1111;
            sign    <= '0;
            dp      <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: if (load && !commit) begin
                    val_q   <= value;
                    dpen_q  <= dp_en;
                    dpsel_q <= dp_sel;
                end
                CLAMP: begin
                    neg_q <= val_q[15];
                    sh    <= {16'd0, mag_c};
                    cnt   <= '0;
                end
                SHIFT: begin
                    sh  <= {pre[28:0], 1'b0};
                    cnt <= cnt + 4'd1;
                end
                PLACE: begin
                    num_p   <= num_c;
                    blank_p <= blank_c;
                    sign_p  <= sign_c;
                    dp_p    <= dp_c;
                    commit  <= 1'b1;
                end
                default: ;
            endcase
            // Output register stage: all display outputs change together with done.
            if (commit) begin
                commit <= 1'b0;
                done   <= 1'b1;
                num    <= num_p;
                blank  <= blank_p;
                sign   <= sign_p;
                dp     <= dp_p;
            end
        end
    end

endmodule

// File: tb/tb_sseg_digits.sv
// Directed bench for sseg_digits; expectations follow the build's SSEG_DIGITS_LZB_EN setting.
module tb_sseg_digits;

`ifdef SSEG_DIGITS_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        dp_en = 1'b0;
    logic [1:0]  dp_sel = '0;
    logic        busy, done;
    logic [15:0] num;
    logic [3:0]  blank, sign, dp;

    int n_chk = 0;
    int n_err = 0;

    sseg_digits dut (
        .clk(clk), .reset_n(reset_n), .value(value), .load(load),
        .dp_en(dp_en), .dp_sel(dp_sel), .busy(busy), .done(done),
        .num(num), .blank(blank), .sign(sign), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [15:0] v;
        logic        de;
        logic [1:0]  ds;
        logic [15:0] num;
        logic [3:0]  blank;
        logic [3:0]  sign;
        logic [3:0]  dp;
    } vec_t;

    vec_t vt[11];

    // Launch one conversion; optionally pulse a second load mid-flight at cycle inj_at.
    task automatic conv(input logic [15:0] v, input logic de, input logic [1:0] ds,
                        input int inj_at, output int lat, output bit glitch, output bit busy1);
        logic [27:0] snap;
        snap   = {num, blank, sign, dp};
        glitch = 1'b0;
        busy1  = 1'b0;
        lat    = -1;
        @(negedge clk);
        value = v; dp_en = de; dp_sel = ds; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 1) busy1 = busy;
            if (done) begin lat = k; break; end
            if ({num, blank, sign, dp} !== snap) glitch = 1'b1;
            if (k == inj_at) begin
                @(negedge clk);
                value = 16'd7777; dp_en = 1'b0; dp_sel = 2'd0; load = 1'b1;
                @(posedge clk); #1;
                k++;
                if (done) begin lat = k; break; end
                @(negedge clk);
                load = 1'b0;
            end
        end
    endtask

    task automatic run_vec(input vec_t t, input int inj_at);
        int lat; bit gl; bit b1;
        conv(t.v, t.de, t.ds, inj_at, lat, gl, b1);
        chk($sformatf("lat_%h", t.v), 32'(lat), 32'd17);
        chk($sformatf("busy1_%h", t.v), {31'd0, b1}, 32'd1);
        chk($sformatf("hold_%h", t.v), {31'd0, gl}, 32'd0);
        chk($sformatf("num_%h", t.v), {16'd0, num}, {16'd0, t.num});
        chk($sformatf("blank_%h", t.v), {28'd0, blank}, {28'd0, t.blank});
        chk($sformatf("sign_%h", t.v), {28'd0, sign}, {28'd0, t.sign});
        chk($sformatf("dp_%h", t.v), {28'd0, dp}, {28'd0, t.dp});
        chk($sformatf("busyend_%h", t.v), {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk($sformatf("pulse_%h", t.v), {31'd0, done}, 32'd0);
    endtask

    initial begin
        int ndone;
        int lat; bit gl; bit b1;
        vt[0]  = '{16'd1234, 1'b1, 2'd2, 16'h1234, 4'b0000, 4'b0000, 4'b0100};
        vt[1]  = '{16'hFFFB, 1'b0, 2'd0, 16'h0005, LZB ? 4'b1100 : 4'b0000,
                   LZB ? 4'b0010 : 4'b1000, 4'b0000};
        vt[2]  = '{16'd20000, 1'b0, 2'd0, 16'h9999, 4'b0000, 4'b0000, 4'b0000};
        vt[3]  = '{16'h8000, 1'b0, 2'd0, 16'h0999, 4'b0000, 4'b1000, 4'b0000};
        vt[4]  = '{16'd0, 1'b1, 2'd0, 16'h0000, LZB ? 4'b1110 : 4'b0000, 4'b0000, 4'b0001};
        vt[5]  = '{16'd42, 1'b1, 2'd3, 16'h0042, LZB ? 4'b1100 : 4'b0000, 4'b0000,
                   LZB ? 4'b0000 : 4'b1000};
        vt[6]  = '{16'hFF85, 1'b1, 2'd3, 16'h0123, 4'b0000, 4'b1000, 4'b0000};  // -123
        vt[7]  = '{16'd9999, 1'b1, 2'd0, 16'h9999, 4'b0000, 4'b0000, 4'b0001};
        vt[8]  = '{16'd10000, 1'b0, 2'd1, 16'h9999, 4'b0000, 4'b0000, 4'b0000};
        vt[9]  = '{16'hFC18, 1'b0, 2'd0, 16'h0999, 4'b0000, 4'b1000, 4'b0000};  // -1000
        vt[10] = '{16'hFFF9, 1'b1, 2'd1, 16'h0007, LZB ? 4'b1100 : 4'b0000,
                   LZB ? 4'b0010 : 4'b1000, LZB ? 4'b0000 : 4'b0010};         // -7

        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out", {4'd0, num, blank, sign, dp}, {4'd0, 16'h0000, 4'b1111, 4'b0000, 4'b0000});
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vt[i]) run_vec(vt[i], 0);

        // Second load while busy must not disturb or queue behind the first.
        run_vec(vt[0], 5);
        ndone = 0;
        repeat (25) begin @(posedge clk); #1; if (done) ndone++; end
        chk("noqueue", 32'(ndone), 32'd0);

        // Reset at T+8 aborts the conversion.
        @(negedge clk);
        value = 16'd4321; dp_en = 1'b1; dp_sel = 2'd1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        ndone = 0;
        repeat (8) begin @(posedge clk); #1; if (done) ndone++; end
        reset_n = 1'b0;
        #1;
        chk("abort_out", {4'd0, num, blank, sign, dp}, {4'd0, 16'h0000, 4'b1111, 4'b0000, 4'b0000});
        chk("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (25) begin @(posedge clk); #1; if (done) ndone++; end
        chk("abort_nodone", 32'(ndone), 32'd0);

        conv(16'd5678, 1'b0, 2'd0, 0, lat, gl, b1);
        chk("recover_lat", 32'(lat), 32'd17);
        chk("recover_num", {16'd0, num}, 32'h0000_5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sseg_digits.md
SSEG_DIGITS -- requirements
Module: sseg_digits

Interface
REQ-001 The block SHALL have no parameters; digit count is fixed at 4, with digit 0 rightmost.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 value  input  16  signed two's-complement number to display.
REQ-005 load  input  1  one-cycle request to convert value; sampled only in IDLE.
REQ-006 dp_en  input  1  decimal point enable; captured with load.
REQ-007 dp_sel  input  2  digit index carrying the decimal point; captured with load.
REQ-008 busy  output  1  high from the cycle after load is accepted until done.
REQ-009 done  output  1  one-cycle pulse when the display outputs update.
REQ-010 num  output  16  four BCD nibbles; num[4i+3:4i] feeds digit i.
REQ-011 blank  output  4  per-digit blank, active-high; feeds each digit decoder's en.
REQ-012 sign  output  4  per-digit minus-sign select, active-high.
REQ-013 dp  output  4  per-digit decimal point, active-high.

Function
REQ-014 FSM states SHALL be IDLE, CLAMP, SHIFT, PLACE, with transitions IDLE->CLAMP on load, CLAMP->SHIFT, SHIFT->PLACE after 14 iterations, and PLACE->IDLE.
REQ-015 load while busy SHALL be ignored; no queuing.
REQ-016 CLAMP SHALL latch neg = value[15] and magnitude = |value|, saturating positive values >9999 to 9999 and negative values <-999 to 999 (neg kept).
REQ-017 SHIFT SHALL run the 14-bit double-dabble: each cycle, add 3 to every BCD nibble >=5, then shift left 1 bit.
REQ-018 Latency SHALL be fixed: load accepted at edge T, outputs updated and done high for exactly one cycle at edge T+17, busy low from T+17.
REQ-019 num, blank, sign and dp SHALL hold their previous values until the T+17 update; there are no intermediate glitches.
REQ-020 Blanking SHALL be computed in PLACE per REQ-026/REQ-027.
REQ-021 Sign SHALL occupy exactly one digit when neg=1, with blank=0 and num=0 in that digit; neg=0 SHALL give sign=0.
REQ-022 dp SHALL be one-hot at dp_sel when dp_en=1 and zero otherwise.
REQ-023 dp SHALL be forced to 0 on any blanked digit or sign digit.
REQ-024 Value 0 SHALL display as digit0=0, with all other digits blanked, or shown as zeros without blanking.

Reset
REQ-025 On reset_n low, the block SHALL enter IDLE asynchronously and set busy=0, done=0, num=0, blank=4'b1111, sign=0 and dp=0; reset mid-conversion SHALL abort it with no done pulse.

Configuration
REQ-026 With SSEG_DIGITS_LZB_EN defined, leading zeros above the most-significant non-zero digit SHALL be blanked, digit0 SHALL never be blanked, and the sign SHALL go in the digit immediately left of the most-significant displayed digit.
REQ-027 With SSEG_DIGITS_LZB_EN undefined, blank SHALL be 0 for all digits after the first conversion, leading zeros SHALL be shown, and the sign, when present, SHALL go in digit 3 (magnitude <=999 guaranteed by the clamp).

Structure
REQ-028 Package sseg_pkg SHALL hold the FSM state enum, NDIG=4, MAX_POS=9999, MAX_NEG_MAG=999 and ITER=14.
REQ-029 Sub-module bcd_adj3 SHALL implement the combinational per-nibble add-3 step, instantiated once per nibble.

Verification
REQ-030 value=1234, dp_en=1, dp_sel=2, load -> at T+17 num=0x1234, blank=0000, sign=0000, dp=0100, with a single done pulse.
REQ-031 value=-5 (0xFFFB), LZB on -> num[3:0]=5, sign=0010, blank=1100; LZB off -> num=0x0005, sign=1000, blank=0000.
REQ-032 value=20000 -> num=0x9999; value=-32768 -> magnitude 999 with sign in digit 3.
REQ-033 value=0, LZB on -> num=0x0000, blank=1110, sign=0.
REQ-034 Reset asserted at T+8 of a conversion -> outputs return to reset values immediately and no done pulse occurs; a load during busy -> ignored, and the first result is unchanged.
